crack_scheduler: RTL

Work-queue scheduler for the RC4 key-search engine. It splits the secret-key space into fixed-size chunks and hands them to NUM_CORES cracking cores, issuing one chunk per cycle with round-robin selection among idle cores. It collects each core's chunk-exhausted or key-found report, aborts all cores on the first hit, and presents the final key and status to the top level. It sits between the board-level start/LED/HEX logic and the array of cracking cores. Each core runs its own init/shuffle/decrypt sequencing.

---
 rtl/crack_pkg.sv | 20 ++
 rtl/rr_picker.sv | 25 ++
 rtl/crack_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/crack_pkg.sv
// Shared definitions for the RC4 key-search engine: scheduler states,
// status LED encodings and the default key-space constants.
package crack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DRAIN,
        ST_FOUND,
        ST_FAIL
    } crack_state_t;

    localparam logic [1:0] LED_OFF   = 2'b00;
    localparam logic [1:0] LED_FOUND = 2'b01;
    localparam logic [1:0] LED_FAIL  = 2'b10;

    localparam int          DEFAULT_KEY_W   = 24;
    localparam logic [23:0] DEFAULT_KEY_MAX = 24'h3FFFFF;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: grants the first set request at or
// after ptr, wrapping modulo N.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant = IDX_W'((int'(ptr) + k) % N);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crack_scheduler.sv
// Work-queue scheduler: hands fixed-size key chunks to idle cracking cores
// round-robin, aborts everything on the first hit and reports key/status.
module crack_scheduler
    import crack_pkg::*;
#(
    parameter int               NUM_CORES = 4,
    parameter int               KEY_W     = DEFAULT_KEY_W,
    parameter logic [KEY_W-1:0] KEY_MAX   = KEY_W'(DEFAULT_KEY_MAX),
    parameter logic [KEY_W-1:0] CHUNK     = KEY_W'(24'h010000)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    output logic [NUM_CORES-1:0]       core_start,
    output logic [KEY_W-1:0]           chunk_first,
    output logic [KEY_W-1:0]           chunk_last,
    output logic                       core_abort,
    input  logic [NUM_CORES-1:0]       core_done,
    input  logic [NUM_CORES-1:0]       core_found,
    input  logic [NUM_CORES*KEY_W-1:0] core_key,
    output logic                       found,
    output logic [KEY_W-1:0]           key_out,
    output logic                       fail,
    output logic                       busy,
    output logic [1:0]                 status_led
);

    localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int BASE_W = KEY_W + 1;

    localparam logic [BASE_W-1:0]  MAX_EXT   = {1'b0, KEY_MAX};
    localparam logic [BASE_W-1:0]  CHUNK_EXT = {1'b0, CHUNK};
    localparam logic [KEY_W+1:0]   MAX_WIDE  = {2'b00, KEY_MAX};
    localparam logic [KEY_W+1:0]   CHUNK_WD  = {2'b00, CHUNK};

    crack_state_t         state, state_nxt;
    logic [BASE_W-1:0]    next_base, next_base_nxt;
    logic [NUM_CORES-1:0] core_busy, core_busy_nxt;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;

    logic [NUM_CORES-1:0] core_start_nxt;
    logic [KEY_W-1:0]     chunk_first_nxt, chunk_last_nxt, key_out_nxt;
    logic                 core_abort_nxt, found_nxt, fail_nxt, busy_nxt;
    logic [1:0]           status_led_nxt;

    logic                 restart, searching, may_dispatch;
    logic [BASE_W-1:0]    eff_base;
    logic [NUM_CORES-1:0] eff_busy, found_req;
    logic [IDX_W-1:0]     eff_ptr, idle_grant, found_grant;
    logic                 idle_valid, found_valid;
    logic [KEY_W+1:0]     chunk_end;

    // A restart dispatches chunk 0 on the same edge, so the dispatch path
    // sees the post-restart base/busy/pointer rather than the registers.
    assign restart   = start && (state == ST_IDLE || state == ST_FOUND || state == ST_FAIL);
    assign searching = (state == ST_SEARCH) || (state == ST_DRAIN);
    assign eff_base  = restart ? '0 : next_base;
    assign eff_busy  = restart ? '0 : core_busy;
    assign eff_ptr   = restart ? '0 : rr_ptr;
    assign found_req = searching ? (core_found & core_busy) : '0;
    assign chunk_end = {1'b0, eff_base} + CHUNK_WD - (KEY_W+2)'(1);

    rr_picker #(.N(NUM_CORES), .IDX_W(IDX_W)) u_idle_pick (
        .req   (~eff_busy),
        .ptr   (eff_ptr),
        .grant (idle_grant),
        .valid (idle_valid)
    );

    rr_picker #(.N(NUM_CORES), .IDX_W(IDX_W)) u_found_pick (
        .req   (found_req),
        .ptr   (rr_ptr),
        .grant (found_grant),
        .valid (found_valid)
    );

    assign may_dispatch = (restart || (state == ST_SEARCH)) && !found_valid
                          && (eff_base <= MAX_EXT) && idle_valid;

    always_comb begin
        state_nxt       = state;
        next_base_nxt   = next_base;
        core_busy_nxt   = core_busy;
        rr_ptr_nxt      = rr_ptr;
        core_start_nxt  = '0;
        chunk_first_nxt = chunk_first;
        chunk_last_nxt  = chunk_last;
        core_abort_nxt  = 1'b0;
        found_nxt       = found;
        fail_nxt        = fail;
        key_out_nxt     = key_out;

        if (restart) begin
            core_abort_nxt = (state == ST_FOUND);
            found_nxt      = 1'b0;
            fail_nxt       = 1'b0;
            key_out_nxt    = '0;
            next_base_nxt  = '0;
            core_busy_nxt  = '0;
            rr_ptr_nxt     = '0;
            state_nxt      = ST_SEARCH;
        end else if (found_valid) begin
            key_out_nxt    = core_key[int'(found_grant)*KEY_W +: KEY_W];
            found_nxt      = 1'b1;
            core_abort_nxt = 1'b1;
            core_busy_nxt  = '0;
            state_nxt      = ST_FOUND;
        end else if (searching) begin
            core_busy_nxt = core_busy & ~core_done;
            if (state == ST_DRAIN && core_busy_nxt == '0) begin
                fail_nxt  = 1'b1;
                state_nxt = ST_FAIL;
            end
        end

        // Grant is drawn from the pre-done idle set, so a core that just
        // reported done waits one cycle before its next chunk.
        if (may_dispatch) begin
            core_start_nxt[idle_grant] = 1'b1;
            core_busy_nxt[idle_grant]  = 1'b1;
            chunk_first_nxt = eff_base[KEY_W-1:0];
            chunk_last_nxt  = (chunk_end > MAX_WIDE) ? KEY_MAX : chunk_end[KEY_W-1:0];
            next_base_nxt   = eff_base + CHUNK_EXT;
            rr_ptr_nxt      = (idle_grant == IDX_W'(NUM_CORES - 1)) ? '0
                                                                     : idle_grant + IDX_W'(1);
            if (next_base_nxt > MAX_EXT) begin
                state_nxt = ST_DRAIN;
            end
        end

        busy_nxt       = (state_nxt == ST_SEARCH) || (state_nxt == ST_DRAIN);
        status_led_nxt = found_nxt ? LED_FOUND : (fail_nxt ? LED_FAIL : LED_OFF);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            next_base   <= '0;
            core_busy   <= '0;
            rr_ptr      <= '0;
            core_start  <= '0;
            chunk_first <= '0;
            chunk_last  <= '0;
            core_abort  <= 1'b0;
            found       <= 1'b0;
            fail        <= 1'b0;
            busy        <= 1'b0;
            key_out     <= '0;
            status_led  <= LED_OFF;
        end else begin
            state       <= state_nxt;
            next_base   <= next_base_nxt;
            core_busy   <= core_busy_nxt;
            rr_ptr      <= rr_ptr_nxt;
            core_start  <= core_start_nxt;
            chunk_first <= chunk_first_nxt;
            chunk_last  <= chunk_last_nxt;
            core_abort  <= core_abort_nxt;
            found       <= found_nxt;
            fail        <= fail_nxt;
            busy        <= busy_nxt;
            key_out     <= key_out_nxt;
            status_led  <= status_led_nxt;
        end
    end

endmodule
